// File: rtl/bank_mapper_e0_fe.sv
// -----------------------------------------------------------------------------
// bank_mapper_e0_fe
//
// Cartridge bank-switch mapper for two 8K schemes:
//   - Parker Brothers E0: four 1K segments. Segments 0..2 are selectable and
//     segment 3 is fixed to slice 7. Slices are switched by touching
//     1FE0..1FF7.
//   - Activision FE: two 4K banks. The bank is switched on the bus cycle that
//     follows a stack access at 01FE. The new bank is ~data[5] of that cycle.
// Plain 2K/4K carts (mode 00, or 11 which is treated the same) pass A11..A0
// straight through to the ROM.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   ena          one-clk strobe per 6507 bus cycle; gates every state update
//   mode[1:0]    00 plain, 01 E0, 10 FE, 11 plain (static after ROM load)
//   cpu_addr     CPU address A12..A0
//   cpu_data     CPU data bus value for the current cycle
//   rom_addr     translated 15-bit ROM address (combinational)
//   bank_change  one-clk pulse in the clk after a slice/bank register write
// -----------------------------------------------------------------------------
module bank_mapper_e0_fe (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic [1:0]  mode,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    output logic [14:0] rom_addr,
    output logic        bank_change
);

    localparam logic [1:0]  MODE_PLAIN = 2'b00;
    localparam logic [1:0]  MODE_E0    = 2'b01;
    localparam logic [1:0]  MODE_FE    = 2'b10;
    localparam logic [12:0] FE_TRIGGER = 13'h01FE;

    typedef enum logic {
        FE_IDLE  = 1'b0,
        FE_ARMED = 1'b1
    } fe_state_t;

    fe_state_t   state_reg, state_next;
    logic [1:0]  mode_eff;
    logic [1:0]  mode_reg;
    logic        fe_bank_reg;
    logic        bank_change_reg;
    logic        e0_hotspot;
    logic        e0_load;
    logic        fe_load;
    logic [2:0]  seg_all [3];
    logic [2:0]  e0_slice;

    // Mode 11 behaves exactly like plain mode.
    assign mode_eff = (mode == 2'b11) ? MODE_PLAIN : mode;

    // 1FE0..1FF7: A12..A5 all ones, and A4..A3 not 11 (1FF8..1FFF excluded).
    assign e0_hotspot = (cpu_addr[12:5] == 8'hFF) && (cpu_addr[4:3] != 2'b11);
    assign e0_load    = ena && (mode_eff == MODE_E0) && e0_hotspot;

    // Tracks the mode seen on the previous clk. It is not reset on purpose: a
    // reset does not change the mode, so it must not look like a mode change.
    always_ff @(posedge clk) begin
        mode_reg <= mode_eff;
    end

    // FE state machine: next-state and capture strobe.
    always_comb begin
        state_next = state_reg;
        fe_load    = 1'b0;
        if (mode_eff != MODE_FE || mode_eff != mode_reg) begin
            // Outside FE mode, and on the first clk of any new mode, the
            // machine is held idle.
            state_next = FE_IDLE;
        end else if (ena) begin
            case (state_reg)
                FE_IDLE: begin
                    if (cpu_addr == FE_TRIGGER) begin
                        state_next = FE_ARMED;
                    end
                end
                FE_ARMED: begin
                    fe_load    = 1'b1;
                    // Back-to-back 01FE accesses keep the machine armed.
                    state_next = (cpu_addr == FE_TRIGGER) ? FE_ARMED : FE_IDLE;
                end
                default: state_next = FE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= FE_IDLE;
            fe_bank_reg     <= 1'b0;
            bank_change_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            if (fe_load) begin
                fe_bank_reg <= ~cpu_data[5];
            end
            // Pulses on every write, including a rewrite with the same value.
            bank_change_reg <= e0_load || fe_load;
        end
    end

    // E0 slice registers seg0..seg2; reset values are 4, 5 and 6.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_seg
            logic [2:0] seg_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    seg_reg <= 3'(4 + gi);
                end else if (e0_load && (cpu_addr[4:3] == 2'(gi))) begin
                    seg_reg <= cpu_addr[2:0];
                end
            end
            assign seg_all[gi] = seg_reg;
        end
    endgenerate

    // Segment 3 is fixed to slice 7, which also covers the hotspot range, so a
    // hotspot cycle is always served from the fixed slice.
    always_comb begin
        e0_slice = 3'd7;
        case (cpu_addr[11:10])
            2'd0:    e0_slice = seg_all[0];
            2'd1:    e0_slice = seg_all[1];
            2'd2:    e0_slice = seg_all[2];
            default: e0_slice = 3'd7;
        endcase
    end

    always_comb begin
        rom_addr = {3'b000, cpu_addr[11:0]};
        case (mode_eff)
            MODE_E0: rom_addr = {2'b00, e0_slice, cpu_addr[9:0]};
            MODE_FE: rom_addr = {2'b00, fe_bank_reg, cpu_addr[11:0]};
            default: rom_addr = {3'b000, cpu_addr[11:0]};
        endcase
    end

    assign bank_change = bank_change_reg;

endmodule

// File: tb/tb_bank_mapper_e0_fe.sv
// -----------------------------------------------------------------------------
// tb_bank_mapper_e0_fe
//
// Directed-vector bench for bank_mapper_e0_fe. The inputs are driven on the
// falling edge, so every bus cycle spans exactly one rising edge. Outputs are
// sampled on the falling edge, or 1 ns after an input change for rom_addr.
// -----------------------------------------------------------------------------
module tb_bank_mapper_e0_fe;

    logic        clk;
    logic        reset;
    logic        ena;
    logic [1:0]  mode;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic [14:0] rom_addr;
    logic        bank_change;

    int check_count = 0;
    int error_count = 0;

    bank_mapper_e0_fe dut (
        .clk         (clk),
        .reset       (reset),
        .ena         (ena),
        .mode        (mode),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .rom_addr    (rom_addr),
        .bank_change (bank_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Drives a reset pulse that spans one rising edge, with ena low.
    task automatic do_reset();
        @(negedge clk);
        ena   = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Applies an address with ena low and checks the combinational mapping.
    task automatic probe(input string tag, input logic [12:0] addr,
                         input logic [14:0] exp_rom);
        @(negedge clk);
        ena      = 1'b0;
        cpu_addr = addr;
        #1;
        check_value(tag, 32'(rom_addr), 32'(exp_rom));
    endtask

    // Runs one CPU bus cycle. It checks the mapping during the cycle, then
    // bank_change in the clk after the edge, then that the pulse has ended.
    task automatic bus_cycle(input string tag, input logic [12:0] addr,
                             input logic [7:0] data, input logic [14:0] exp_rom,
                             input logic exp_bc);
        @(negedge clk);
        ena      = 1'b1;
        cpu_addr = addr;
        cpu_data = data;
        #1;
        check_value({tag, ".rom"}, 32'(rom_addr), 32'(exp_rom));
        @(negedge clk);
        ena = 1'b0;
        check_value({tag, ".bc"}, 32'(bank_change), 32'(exp_bc));
        @(negedge clk);
        check_value({tag, ".bc_end"}, 32'(bank_change), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        ena      = 1'b0;
        mode     = 2'b01;
        cpu_addr = 13'h0000;
        cpu_data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // ---------------- E0 mode ----------------
        check_value("e0_reset_bc", 32'(bank_change), 32'd0);
        probe("e0_reset_s0", 13'h0123, 15'h1123);
        probe("e0_reset_s1", 13'h0400, 15'h1400);
        probe("e0_reset_s2", 13'h0800, 15'h1800);
        probe("e0_reset_s3", 13'h0C55, 15'h1C55);

        bus_cycle("e0_hot_1fe2", 13'h1FE2, 8'h00, 15'h1FE2, 1'b1);
        probe("e0_seg0_2", 13'h0010, 15'h0810);
        bus_cycle("e0_hot_1feb", 13'h1FEB, 8'hFF, 15'h1FEB, 1'b1);
        probe("e0_seg1_3", 13'h0400, 15'h0C00);

        // Hotspot address with ena low: nothing may change.
        @(negedge clk);
        cpu_addr = 13'h1FF7;
        @(negedge clk);
        check_value("e0_noena_bc", 32'(bank_change), 32'd0);
        probe("e0_noena_seg2", 13'h0800, 15'h1800);

        // Just past the hotspot range.
        bus_cycle("e0_1ff8", 13'h1FF8, 8'h00, 15'h1FF8, 1'b0);
        probe("e0_1ff8_seg2", 13'h0800, 15'h1800);
        probe("e0_1ff8_seg0", 13'h0000, 15'h0800);

        // Top of the hotspot range.
        bus_cycle("e0_1ff7", 13'h1FF7, 8'h00, 15'h1FF7, 1'b1);
        probe("e0_seg2_7", 13'h0ABC, 15'h1EBC);

        // Rewriting the same value still pulses bank_change.
        bus_cycle("e0_rewrite", 13'h1FE2, 8'h00, 15'h1FE2, 1'b1);
        probe("e0_rewrite_map", 13'h0010, 15'h0810);

        // ---------------- FE mode ----------------
        @(negedge clk);
        mode = 2'b10;
        repeat (2) @(negedge clk);
        probe("fe_bank0", 13'h1000, 15'h0000);

        bus_cycle("fe_arm_a", 13'h01FE, 8'h00, 15'h01FE, 1'b0);
        bus_cycle("fe_sw_d0", 13'h0123, 8'hD0, 15'h0123, 1'b1);
        probe("fe_bank1", 13'h1000, 15'h1000);

        bus_cycle("fe_arm_b", 13'h01FE, 8'h00, 15'h11FE, 1'b0);
        bus_cycle("fe_sw_f0", 13'h0123, 8'hF0, 15'h1123, 1'b1);
        probe("fe_bank0_again", 13'h1000, 15'h0000);

        // A plain access without arming must not switch.
        bus_cycle("fe_unarmed", 13'h0200, 8'h00, 15'h0200, 1'b0);
        probe("fe_unarmed_map", 13'h1000, 15'h0000);

        // Arm, then switch to bank 1, then arm again and reset before capture.
        bus_cycle("fe_arm_c", 13'h01FE, 8'h00, 15'h01FE, 1'b0);
        bus_cycle("fe_sw_d0b", 13'h0300, 8'hD0, 15'h0300, 1'b1);
        bus_cycle("fe_arm_d", 13'h01FE, 8'h00, 15'h11FE, 1'b0);
        do_reset();
        check_value("fe_rst_bc", 32'(bank_change), 32'd0);
        probe("fe_rst_bank0", 13'h1000, 15'h0000);
        // The FSM must be idle, so data 00 (which would select bank 1) is ignored.
        bus_cycle("fe_rst_nosw", 13'h0100, 8'h00, 15'h0100, 1'b0);
        probe("fe_rst_still0", 13'h1000, 15'h0000);

        // ---------------- Plain mode ----------------
        @(negedge clk);
        mode = 2'b00;
        repeat (2) @(negedge clk);
        bus_cycle("pl_0000", 13'h0000, 8'h00, 15'h0000, 1'b0);
        bus_cycle("pl_0123", 13'h0123, 8'h00, 15'h0123, 1'b0);
        bus_cycle("pl_0fff", 13'h0FFF, 8'h00, 15'h0FFF, 1'b0);
        bus_cycle("pl_1c55", 13'h1C55, 8'h00, 15'h0C55, 1'b0);
        bus_cycle("pl_1fe0", 13'h1FE0, 8'h00, 15'h0FE0, 1'b0);
        bus_cycle("pl_1fe2", 13'h1FE2, 8'h00, 15'h0FE2, 1'b0);
        bus_cycle("pl_01fe", 13'h01FE, 8'h00, 15'h01FE, 1'b0);
        bus_cycle("pl_after", 13'h0100, 8'h00, 15'h0100, 1'b0);

        // Mode 11 behaves as plain mode.
        @(negedge clk);
        mode = 2'b11;
        bus_cycle("m11_1fe4", 13'h1FE4, 8'h00, 15'h0FE4, 1'b0);

        // The registers are kept across mode changes. The E0 slices are still
        // the reset values, and plain-mode hotspot hits must not have changed
        // them.
        @(negedge clk);
        mode = 2'b01;
        probe("e0_kept_s0", 13'h0010, 15'h1010);
        probe("e0_kept_s2", 13'h0800, 15'h1800);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
